// File: rtl/ts_frame_uart_tx_pkg.sv
// rtl/ts_frame_uart_tx_pkg.sv - shared state encodings, parity modes and header constant
package ts_frame_uart_tx_pkg;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_PAR,
    BIT_STOP
  } bit_state_t;

  typedef enum logic {
    FR_IDLE,
    FR_SEND
  } frame_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  function automatic logic parity_of(input int mode, input logic [7:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/ts_frame_uart_tx_byte.sv
// rtl/ts_frame_uart_tx_byte.sv - baud divider and bit shifter for one UART character
module ts_frame_uart_tx_byte
  import ts_frame_uart_tx_pkg::*;
#(
  parameter int DIV    = 10,
  parameter int PARITY = 0,
  parameter int STOP_B = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx,
  output logic       tick,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  bit_state_t    state;
  logic [CW-1:0] cnt;
  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic          par_q;

  assign tick = busy && (cnt == CNT_MAX);
  assign done = tick && (state == BIT_STOP) && (stop_cnt == 1'(STOP_B - 1));

  // A load on the same edge as done chains the next character with no idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BIT_IDLE;
      cnt      <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
      busy     <= 1'b0;
      tx       <= 1'b1;
    end else if (ld) begin
      state    <= BIT_START;
      cnt      <= '0;
      sh       <= data;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= parity_of(PARITY, data);
      busy     <= 1'b1;
      tx       <= 1'b0;
    end else if (busy) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        case (state)
          BIT_START: begin
            state <= BIT_DATA;
            tx    <= sh[0];
            sh    <= sh >> 1;
          end
          BIT_DATA: begin
            if (bit_cnt == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= BIT_PAR;
                tx    <= par_q;
              end else begin
                state <= BIT_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= sh[0];
              sh      <= sh >> 1;
            end
          end
          BIT_PAR: begin
            state <= BIT_STOP;
            tx    <= 1'b1;
          end
          BIT_STOP: begin
            if (stop_cnt == 1'(STOP_B - 1)) begin
              state <= BIT_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
            tx <= 1'b1;
          end
          default: state <= BIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ts_frame_uart_tx.sv
// rtl/ts_frame_uart_tx.sv - framed time-stamp sender: header, channel, stamp bytes, XOR checksum
module ts_frame_uart_tx
  import ts_frame_uart_tx_pkg::*;
#(
  parameter int         CLK_HZ = 10_000_000,
  parameter int         BAUD   = 115_200,
  parameter int         TS_W   = 8,
  parameter int         PARITY = 0,
  parameter int         STOP_B = 1,
  parameter logic [7:0] HDR    = HDR_DEFAULT
) (
  input  logic            clk_10M,
  input  logic            rst,
  input  logic            start,
  input  logic [TS_W-1:0] ts_in,
  input  logic [7:0]      ch_id,
  output logic            tx_serial,
  output logic            busy,
  output logic            baud_tick,
  output logic [3:0]      byte_idx,
  output logic            frame_done,
  output logic            overrun
);

  localparam int         DIV      = CLK_HZ / BAUD;
  localparam int         NB       = (TS_W + 7) / 8;
  localparam logic [3:0] LAST_IDX = 4'(NB + 2);

  frame_state_t    state;
  logic [NB*8-1:0] ts_q;
  logic [7:0]      ch_q;
  logic [7:0]      csum_q;
  logic [NB*8-1:0] ts_pad;
  logic [7:0]      csum_in;
  logic [3:0]      nxt_idx;
  logic [7:0]      nxt_byte;
  logic            accept;
  logic            ld;
  logic [7:0]      ld_byte;
  logic            line_busy;
  logic            byte_done;

  always_comb begin
    ts_pad  = (NB*8)'(ts_in);
    csum_in = ch_id;
    for (int i = 0; i < NB; i++) begin
      csum_in = csum_in ^ ts_pad[8*i +: 8];
    end
  end

  always_comb begin
    nxt_idx  = byte_idx + 4'd1;
    nxt_byte = csum_q;
    if (nxt_idx == 4'd1) begin
      nxt_byte = ch_q;
    end
    for (int i = 0; i < NB; i++) begin
      if (nxt_idx == 4'(i + 2)) begin
        nxt_byte = ts_q[8*i +: 8];
      end
    end
  end

  // The frame_done cycle still counts as occupied, so a request landing there is an overrun.
  assign accept  = start && !busy && !frame_done;
  assign ld      = accept || (byte_done && line_busy && (byte_idx != LAST_IDX));
  assign ld_byte = accept ? HDR : nxt_byte;

  ts_frame_uart_tx_byte #(
    .DIV    (DIV),
    .PARITY (PARITY),
    .STOP_B (STOP_B)
  ) u_byte (
    .clk  (clk_10M),
    .rst  (rst),
    .ld   (ld),
    .data (ld_byte),
    .busy (line_busy),
    .tx   (tx_serial),
    .tick (baud_tick),
    .done (byte_done)
  );

  always_ff @(posedge clk_10M or posedge rst) begin
    if (rst) begin
      state      <= FR_IDLE;
      ts_q       <= '0;
      ch_q       <= '0;
      csum_q     <= '0;
      busy       <= 1'b0;
      byte_idx   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= start && (busy || frame_done);
      frame_done <= 1'b0;
      case (state)
        FR_IDLE: begin
          if (accept) begin
            ts_q     <= ts_pad;
            ch_q     <= ch_id;
            csum_q   <= csum_in;
            busy     <= 1'b1;
            byte_idx <= '0;
            state    <= FR_SEND;
          end
        end
        FR_SEND: begin
          if (byte_done && line_busy) begin
            if (byte_idx == LAST_IDX) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              byte_idx   <= '0;
              state      <= FR_IDLE;
            end else begin
              byte_idx <= nxt_idx;
            end
          end
        end
        default: state <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_frame_uart_tx.sv
// tb/tb_ts_frame_uart_tx.sv - directed bench: three parameterisations of ts_frame_uart_tx at DIV=10
module tb_ts_frame_uart_tx;

  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1, start2;
  logic [7:0]  ts0, ts2;
  logic [15:0] ts1;
  logic [7:0]  ch0, ch1, ch2;
  logic        tx0, tx1, tx2, busy0, busy1, busy2, bt0, bt1, bt2;
  logic        fd0, fd1, fd2, ov0, ov1, ov2;
  logic [3:0]  idx0, idx1, idx2;

  ts_frame_uart_tx #(.CLK_HZ(10_000_000), .BAUD(1_000_000), .TS_W(8), .PARITY(0), .STOP_B(1)) dut0 (
    .clk_10M(clk), .rst(rst), .start(start0), .ts_in(ts0), .ch_id(ch0), .tx_serial(tx0), .busy(busy0),
    .baud_tick(bt0), .byte_idx(idx0), .frame_done(fd0), .overrun(ov0));

  ts_frame_uart_tx #(.CLK_HZ(10_000_000), .BAUD(1_000_000), .TS_W(16), .PARITY(1), .STOP_B(1)) dut1 (
    .clk_10M(clk), .rst(rst), .start(start1), .ts_in(ts1), .ch_id(ch1), .tx_serial(tx1), .busy(busy1),
    .baud_tick(bt1), .byte_idx(idx1), .frame_done(fd1), .overrun(ov1));

  ts_frame_uart_tx #(.CLK_HZ(10_000_000), .BAUD(1_000_000), .TS_W(8), .PARITY(2), .STOP_B(2)) dut2 (
    .clk_10M(clk), .rst(rst), .start(start2), .ts_in(ts2), .ch_id(ch2), .tx_serial(tx2), .busy(busy2),
    .baud_tick(bt2), .byte_idx(idx2), .frame_done(fd2), .overrun(ov2));

  int         sel = 0;
  logic       tx_m, busy_m, bt_m, fd_m, ov_m;
  logic [3:0] idx_m;

  always_comb begin
    case (sel)
      1:       begin tx_m = tx1; busy_m = busy1; bt_m = bt1; fd_m = fd1; ov_m = ov1; idx_m = idx1; end
      2:       begin tx_m = tx2; busy_m = busy2; bt_m = bt2; fd_m = fd2; ov_m = ov2; idx_m = idx2; end
      default: begin tx_m = tx0; busy_m = busy0; bt_m = bt0; fd_m = fd0; ov_m = ov0; idx_m = idx0; end
    endcase
  end

  int cyc = 0;
  int tick_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bt_m === 1'b1) tick_cnt <= tick_cnt + 1;

  int         checks = 0;
  int         errors = 0;
  int         acc_cyc;
  int         done_cyc;
  int         ferr;
  int         idx_err;
  logic [7:0] rx [0:7];

  task automatic do_start(input int s);
    @(negedge clk);
    case (s)
      1:       start1 = 1'b1;
      2:       start2 = 1'b1;
      default: start0 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    acc_cyc = cyc;
  endtask

  // Samples each bit mid-cell; returns bytes in rx, framing/parity slips in ferr.
  task automatic recv_frame(input int nbytes, input int par, input int stopb);
    logic [7:0] d;
    logic       pexp;
    ferr = 0;
    idx_err = 0;
    repeat (DIV/2) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      if (tx_m !== 1'b0) ferr++;
      if (idx_m !== 4'(b)) idx_err++;
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clk);
        d[k] = tx_m;
      end
      rx[b] = d;
      if (par != 0) begin
        repeat (DIV) @(negedge clk);
        pexp = (par == 2) ? ~^d : ^d;
        if (tx_m !== pexp) ferr++;
      end
      for (int s = 0; s < stopb; s++) begin
        repeat (DIV) @(negedge clk);
        if (tx_m !== 1'b1) ferr++;
      end
      if (b != nbytes - 1) repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (fd_m === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ts0 = '0; ts1 = '0; ts2 = '0; ch0 = '0; ch1 = '0; ch2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, busy0, bt0, idx0, fd0, ov0} !== 9'b1_0_0_0000_0_0) begin
      errors++;
      $display("FAIL reset_dut0 got %b exp 100000000", {tx0, busy0, bt0, idx0, fd0, ov0});
    end
    checks++;
    if ({tx1, busy1, bt1, idx1, fd1, ov1, tx2, busy2, bt2, idx2, fd2, ov2} !== 18'b100000000_100000000) begin
      errors++;
      $display("FAIL reset_dut12 got %b", {tx1, busy1, bt1, idx1, fd1, ov1, tx2, busy2, bt2, idx2, fd2, ov2});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp [0:3];
    int t0;
    int seen_busy;
    exp = '{8'hA5, 8'h02, 8'h3C, 8'h3E};
    sel = 0; ch0 = 8'h02; ts0 = 8'h3C;
    @(negedge clk);
    t0 = tick_cnt;
    do_start(0);
    checks++;
    if (busy_m !== 1'b1 || tx_m !== 1'b0) begin
      errors++;
      $display("FAIL t1_latency busy=%b tx=%b exp busy=1 tx=0", busy_m, tx_m);
    end
    recv_frame(4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t1_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    checks++;
    if (ferr !== 0 || idx_err !== 0) begin
      errors++;
      $display("FAIL t1_framing ferr=%0d idx_err=%0d exp 0 0", ferr, idx_err);
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 400) begin
      errors++;
      $display("FAIL t1_length got %0d exp 400", done_cyc - acc_cyc);
    end
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy_drop got %b exp 0", busy_m);
    end
    checks++;
    if (tick_cnt - t0 !== 40) begin
      errors++;
      $display("FAIL t1_ticks got %0d exp 40", tick_cnt - t0);
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (ov_m !== 1'b1 || busy_m !== 1'b0 || fd_m !== 1'b0) begin
      errors++;
      $display("FAIL t1_start_on_done ov=%b busy=%b fd=%b exp 1 0 0", ov_m, busy_m, fd_m);
    end
    seen_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_m !== 1'b0 || tx_m !== 1'b1) seen_busy++;
    end
    checks++;
    if (seen_busy !== 0) begin
      errors++;
      $display("FAIL t1_no_b2b got %0d busy cycles exp 0", seen_busy);
    end
  endtask

  task automatic test_even_parity();
    logic [7:0] exp [0:4];
    int t0;
    exp = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h27};
    sel = 1; ch1 = 8'h01; ts1 = 16'h1234;
    @(negedge clk);
    t0 = tick_cnt;
    do_start(1);
    recv_frame(5, 1, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t2_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    checks++;
    if (ferr !== 0 || idx_err !== 0) begin
      errors++;
      $display("FAIL t2_framing ferr=%0d idx_err=%0d exp 0 0", ferr, idx_err);
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 550) begin
      errors++;
      $display("FAIL t2_length got %0d exp 550", done_cyc - acc_cyc);
    end
    checks++;
    if (tick_cnt - t0 !== 55) begin
      errors++;
      $display("FAIL t2_ticks got %0d exp 55", tick_cnt - t0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [7:0] exp [0:3];
    int seen_busy;
    exp = '{8'hA5, 8'h55, 8'h81, 8'hD4};
    sel = 0; ch0 = 8'h55; ts0 = 8'h81;
    do_start(0);
    fork
      recv_frame(4, 0, 1);
      begin
        repeat (100) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (ov_m !== 1'b1 || busy_m !== 1'b1) begin
          errors++;
          $display("FAIL t3_overrun ov=%b busy=%b exp 1 1", ov_m, busy_m);
        end
        @(negedge clk);
        checks++;
        if (ov_m !== 1'b0) begin
          errors++;
          $display("FAIL t3_overrun_width got %b exp 0", ov_m);
        end
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t3_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 400) begin
      errors++;
      $display("FAIL t3_length got %0d exp 400", done_cyc - acc_cyc);
    end
    seen_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_m !== 1'b0) seen_busy++;
    end
    checks++;
    if (seen_busy !== 0) begin
      errors++;
      $display("FAIL t3_no_second_frame got %0d busy cycles exp 0", seen_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [0:3];
    exp = '{8'hA5, 8'h33, 8'h44, 8'h77};
    sel = 0; ch0 = 8'h11; ts0 = 8'h22;
    do_start(0);
    repeat (215) @(negedge clk);
    checks++;
    if (idx_m !== 4'd2 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL t4_pre_reset idx=%0d busy=%b exp 2 1", idx_m, busy_m);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || idx0 !== 4'd0) begin
      errors++;
      $display("FAIL t4_async_reset tx=%b busy=%b idx=%0d exp 1 0 0", tx0, busy0, idx0);
    end
    @(negedge clk);
    rst = 1'b0;
    ch0 = 8'h33; ts0 = 8'h44;
    repeat (2) @(negedge clk);
    do_start(0);
    recv_frame(4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t4_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 400 || ferr !== 0) begin
      errors++;
      $display("FAIL t4_length got %0d ferr=%0d exp 400 0", done_cyc - acc_cyc, ferr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_odd_two_stop();
    logic [7:0] exp [0:3];
    exp = '{8'hA5, 8'h10, 8'hFF, 8'hEF};
    sel = 2; ch2 = 8'h10; ts2 = 8'hFF;
    do_start(2);
    recv_frame(4, 2, 2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t5_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    checks++;
    if (ferr !== 0 || idx_err !== 0) begin
      errors++;
      $display("FAIL t5_framing ferr=%0d idx_err=%0d exp 0 0", ferr, idx_err);
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 480) begin
      errors++;
      $display("FAIL t5_length got %0d exp 480", done_cyc - acc_cyc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_input_toggle();
    logic [7:0] exp [0:3];
    exp = '{8'hA5, 8'h07, 8'h5A, 8'h5D};
    sel = 0; ch0 = 8'h07; ts0 = 8'h5A;
    do_start(0);
    fork
      recv_frame(4, 0, 1);
      for (int i = 0; i < 405 && busy0 === 1'b1; i++) begin
        ts0 = ~ts0;
        ch0 = ch0 + 8'd1;
        @(negedge clk);
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++;
        $display("FAIL t6_byte%0d got %h exp %h", i, rx[i], exp[i]);
      end
    end
    wait_done();
    checks++;
    if (done_cyc - acc_cyc !== 400) begin
      errors++;
      $display("FAIL t6_length got %0d exp 400", done_cyc - acc_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_even_parity();
    test_overrun();
    test_reset_mid_frame();
    test_odd_two_stop();
    test_input_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
